// File: rtl/decoder_pkg.sv
// Shared decoder/branch types plus the branch predictor's table geometry, pending-update record
// and saturating counter helper.
package decoder_pkg;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } branch_op_t;

    typedef enum logic {
        PC_PLUS4  = 1'b0,
        PC_BRANCH = 1'b1
    } pc_mux_t;

    // Counter table geometry lives here because the pending-update record is shaped by it.
    localparam int BP_ENTRIES  = 64;
    localparam int BP_CTR_BITS = 2;
    localparam int BP_IDX_W    = $clog2(BP_ENTRIES);

    typedef enum logic {
        BP_IDLE  = 1'b0,
        BP_CLEAR = 1'b1
    } bp_state_t;

    typedef struct packed {
        logic                   valid;
        logic [BP_IDX_W-1:0]    idx;
        logic [BP_CTR_BITS-1:0] ctr;
    } bp_pend_t;

    function automatic logic [BP_CTR_BITS-1:0] ctr_step(input logic [BP_CTR_BITS-1:0] c,
                                                        input logic up);
        logic [BP_CTR_BITS-1:0] r;
        r = c;
        if (up) begin
            if (c != {BP_CTR_BITS{1'b1}}) r = c + 1'b1;
        end else begin
            if (c != '0) r = c - 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/branch_predict_unit_cond.sv
// Branch condition evaluator: decides whether a conditional branch is taken for (a, b, op).
// Unknown compare encodings never take.
module branch_cond
    import decoder_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  branch_op_t       op_i,
    output logic             take_o
);

    always_comb begin
        take_o = 1'b0;
        case (op_i)
            BEQ:     take_o = (a_i == b_i);
            BNE:     take_o = (a_i != b_i);
            BLT:     take_o = ($signed(a_i) <  $signed(b_i));
            BGE:     take_o = ($signed(a_i) >= $signed(b_i));
            BLTU:    take_o = (a_i <  b_i);
            BGEU:    take_o = (a_i >= b_i);
            default: take_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Bimodal predictor with pipelined training, a one-entry-per-cycle clear sweep and branch
// resolution. Optional event counters are built when BRANCH_STATS_EN is defined.
module branch_predict_unit
    import decoder_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int CTR_INIT = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] fetch_pc,
    output logic             predict_taken,
    input  logic             resolve_valid,
    input  logic [WIDTH-1:0] resolve_pc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  branch_op_t       op,
    input  logic             branch_always,
    input  logic             branch_instr,
    input  logic             predicted_taken,
    output pc_mux_t          out,
    output logic             mispredict,
    input  logic             clear,
    output logic             busy,
    output logic [31:0]      stat_branches,
    output logic [31:0]      stat_mispred
);

    localparam int ENTRIES  = BP_ENTRIES;
    localparam int CTR_BITS = BP_CTR_BITS;
    localparam int IDX_W    = BP_IDX_W;
    localparam logic [CTR_BITS-1:0] INIT_V = CTR_BITS'(CTR_INIT);

    logic [CTR_BITS-1:0] ctr_q [ENTRIES];
    bp_state_t           state_q, state_d;
    logic [IDX_W-1:0]    clr_idx_q, clr_idx_d;
    logic                clr_we;
    bp_pend_t            pend_q, pend_d;

    logic [IDX_W-1:0]    fetch_idx, res_idx;
    logic [CTR_BITS-1:0] fetch_ctr, res_ctr, res_ctr_new;
    logic                take, taken, cond_resolve, train;
    logic                unused_pc_bits;

    assign fetch_idx      = fetch_pc[IDX_W+1:2];
    assign res_idx        = resolve_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{fetch_pc[WIDTH-1:IDX_W+2], fetch_pc[1:0],
                              resolve_pc[WIDTH-1:IDX_W+2], resolve_pc[1:0]};

    branch_cond #(.WIDTH(WIDTH)) u_cond (
        .a_i    (a),
        .b_i    (b),
        .op_i   (op),
        .take_o (take)
    );

    // The pending update has not reached the table yet, so both readers see it first.
    always_comb begin
        fetch_ctr = ctr_q[fetch_idx];
        if (pend_q.valid && (pend_q.idx == fetch_idx)) fetch_ctr = pend_q.ctr;
        res_ctr = ctr_q[res_idx];
        if (pend_q.valid && (pend_q.idx == res_idx)) res_ctr = pend_q.ctr;
    end

    assign res_ctr_new   = ctr_step(res_ctr, take);
    assign predict_taken = (state_q == BP_IDLE) && fetch_ctr[CTR_BITS-1];

    assign taken        = branch_always | (branch_instr & take);
    assign out          = pc_mux_t'(resolve_valid & taken);
    assign mispredict   = resolve_valid & branch_instr & (take != predicted_taken);
    assign cond_resolve = resolve_valid & branch_instr;
    assign train        = cond_resolve & ~branch_always & (state_q == BP_IDLE) & ~clear;

    always_comb begin
        pend_d       = '0;
        pend_d.valid = train;
        pend_d.idx   = res_idx;
        pend_d.ctr   = res_ctr_new;
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        clr_we    = 1'b0;
        case (state_q)
            BP_IDLE: begin
                if (clear) begin
                    state_d   = BP_CLEAR;
                    clr_idx_d = '0;
                end
            end
            BP_CLEAR: begin
                clr_we    = 1'b1;
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == IDX_W'(ENTRIES - 1)) state_d = BP_IDLE;
            end
            default: state_d = BP_IDLE;
        endcase
    end

    assign busy = (state_q == BP_CLEAR);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= BP_IDLE;
            clr_idx_q <= '0;
            pend_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            pend_q    <= pend_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= INIT_V;
        end else if (clr_we) begin
            ctr_q[clr_idx_q] <= INIT_V;
        end else if (pend_q.valid && (state_q == BP_IDLE)) begin
            ctr_q[pend_q.idx] <= pend_q.ctr;
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_br_q, stat_mis_q;
    logic        start_clear;

    assign start_clear = (state_q == BP_IDLE) && clear;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_br_q  <= '0;
            stat_mis_q <= '0;
        end else if (start_clear) begin
            stat_br_q  <= '0;
            stat_mis_q <= '0;
        end else begin
            if (cond_resolve && (stat_br_q != 32'hFFFF_FFFF)) stat_br_q <= stat_br_q + 32'd1;
            if (mispredict && (stat_mis_q != 32'hFFFF_FFFF)) stat_mis_q <= stat_mis_q + 32'd1;
        end
    end

    assign stat_branches = stat_br_q;
    assign stat_mispred  = stat_mis_q;
`else
    assign stat_branches = 32'd0;
    assign stat_mispred  = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: a driver stages one cycle of inputs and queues the
// expected outputs; a negedge monitor pops and compares.
module tb_branch_predict_unit;
    import decoder_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] fetch_pc, resolve_pc, a, b;
    branch_op_t  op;
    logic        resolve_valid, branch_always, branch_instr, predicted_taken, clear;
    logic        predict_taken, mispredict, busy;
    pc_mux_t     out;
    logic [31:0] stat_branches, stat_mispred;

    always #5 clk = ~clk;

    branch_predict_unit dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .fetch_pc        (fetch_pc),
        .predict_taken   (predict_taken),
        .resolve_valid   (resolve_valid),
        .resolve_pc      (resolve_pc),
        .a               (a),
        .b               (b),
        .op              (op),
        .branch_always   (branch_always),
        .branch_instr    (branch_instr),
        .predicted_taken (predicted_taken),
        .out             (out),
        .mispredict      (mispredict),
        .clear           (clear),
        .busy            (busy),
        .stat_branches   (stat_branches),
        .stat_mispred    (stat_mispred)
    );

    typedef struct packed {
        logic [15:0] id;
        logic m_pred; logic e_pred;
        logic m_busy; logic e_busy;
        logic m_out;  logic e_out;
        logic m_mis;  logic e_mis;
        logic m_stat;
    } exp_t;
    localparam int EXP_W = $bits(exp_t);

    logic [EXP_W-1:0] exp_q[$];
    int checks = 0, errors = 0, issued = 0, seen = 0, step_id = 0;
    exp_t mon_e;

    // Staged inputs applied at the next driver step
    logic [31:0] s_fetch_pc, s_rpc, s_a, s_b;
    branch_op_t  s_op;
    logic        s_rv, s_ba, s_bi, s_pt, s_clear, s_rst_n;

    // ---------------- driver tasks ----------------
    task automatic tick(input int ep, input int eb, input int eo, input int em, input bit cs);
        exp_t e;
        @(posedge clk);
        #1;
        reset_n         = s_rst_n;
        fetch_pc        = s_fetch_pc;
        resolve_valid   = s_rv;
        resolve_pc      = s_rpc;
        a               = s_a;
        b               = s_b;
        op              = s_op;
        branch_always   = s_ba;
        branch_instr    = s_bi;
        predicted_taken = s_pt;
        clear           = s_clear;
        s_rv = 1'b0; s_ba = 1'b0; s_bi = 1'b0; s_pt = 1'b0; s_clear = 1'b0;
        step_id++;
        if (ep >= 0 || eb >= 0 || eo >= 0 || em >= 0 || cs) begin
            e.id     = 16'(step_id);
            e.m_pred = (ep >= 0); e.e_pred = ep[0];
            e.m_busy = (eb >= 0); e.e_busy = eb[0];
            e.m_out  = (eo >= 0); e.e_out  = eo[0];
            e.m_mis  = (em >= 0); e.e_mis  = em[0];
            e.m_stat = cs;
            exp_q.push_back(EXP_W'(e));
            issued++;
        end
    endtask

    task automatic res(input logic [31:0] pc, input branch_op_t o, input logic [31:0] aa,
                       input logic [31:0] bb, input logic bi, input logic ba, input logic pt);
        s_rv = 1'b1; s_rpc = pc; s_op = o; s_a = aa; s_b = bb;
        s_bi = bi; s_ba = ba; s_pt = pt;
    endtask

    // ---------------- scoreboard / monitor ----------------
    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s step=%0d actual=%0h required=%0h", nm, id, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (seen < issued) begin
            mon_e = exp_t'(exp_q.pop_front());
            seen++;
            if (mon_e.m_pred) chk("predict_taken", int'(mon_e.id), 32'(predict_taken), 32'(mon_e.e_pred));
            if (mon_e.m_busy) chk("busy", int'(mon_e.id), 32'(busy), 32'(mon_e.e_busy));
            if (mon_e.m_out)  chk("out", int'(mon_e.id), 32'(out), 32'(mon_e.e_out));
            if (mon_e.m_mis)  chk("mispredict", int'(mon_e.id), 32'(mispredict), 32'(mon_e.e_mis));
            if (mon_e.m_stat) begin
                chk("stat_branches", int'(mon_e.id), stat_branches, 32'd0);
                chk("stat_mispred", int'(mon_e.id), stat_mispred, 32'd0);
            end
        end
    end

    // Condition vectors: op, a, b, expected take
    branch_op_t  v_op [11];
    logic [31:0] v_a  [11];
    logic [31:0] v_b  [11];
    logic        v_t  [11];

    // ---------------- stimulus ----------------
    initial begin
        v_op = '{BLTU, BLT, BGE, BGEU, BEQ, BNE, BLT, BGE, BLTU,
                 branch_op_t'(3'b010), branch_op_t'(3'b011)};
        v_a  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3, 32'd3,
                 32'd1, 32'd5, 32'd1, 32'd5, 32'd5};
        v_b  = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd4, 32'd4, 32'hFFFF_FFFF, 32'd5, 32'd2,
                 32'd5, 32'd5};
        v_t  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

        reset_n = 1'b0; fetch_pc = 32'h40; resolve_valid = 1'b0; resolve_pc = '0;
        a = '0; b = '0; op = BEQ; branch_always = 1'b0; branch_instr = 1'b0;
        predicted_taken = 1'b0; clear = 1'b0;
        s_rst_n = 1'b0; s_fetch_pc = 32'h40; s_rv = 1'b0; s_rpc = '0; s_a = '0; s_b = '0;
        s_op = BEQ; s_ba = 1'b0; s_bi = 1'b0; s_pt = 1'b0; s_clear = 1'b0;

        // Reset state
        tick(0, 0, 0, 0, 1);
        tick(-1, -1, -1, -1, 0);
        s_rst_n = 1'b1;
        tick(0, 0, 0, 0, 1);

        // BEQ taken at 0x40 mispredicted; forwarded next cycle, from the table after
        res(32'h40, BEQ, 32'd5, 32'd5, 1'b1, 1'b0, 1'b0);
        tick(0, 0, 1, 1, 0);
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);

        // 0x80: taken x3 back-to-back (1->2->3->3), not-taken (->2), then not-taken (->1)
        s_fetch_pc = 32'h80;
        res(32'h80, BEQ, 32'd9, 32'd9, 1'b1, 1'b0, 1'b0); tick(0, -1, 1, 1, 0);
        res(32'h80, BEQ, 32'd9, 32'd9, 1'b1, 1'b0, 1'b1); tick(1, -1, 1, 0, 0);
        res(32'h80, BEQ, 32'd9, 32'd9, 1'b1, 1'b0, 1'b1); tick(1, -1, 1, 0, 0);
        res(32'h80, BNE, 32'd7, 32'd7, 1'b1, 1'b0, 1'b1); tick(1, -1, 0, 1, 0);
        tick(1, -1, -1, -1, 0);
        tick(1, -1, -1, -1, 0);
        res(32'h80, BNE, 32'd7, 32'd7, 1'b1, 1'b0, 1'b1); tick(1, -1, 0, 1, 0);
        tick(0, -1, -1, -1, 0);
        tick(0, -1, -1, -1, 0);

        // Compare operations, predicted not-taken so mispredict equals take
        for (int i = 0; i < 11; i++) begin
            res(32'h100, v_op[i], v_a[i], v_b[i], 1'b1, 1'b0, 1'b0);
            tick(0, -1, int'(v_t[i]), int'(v_t[i]), 0);
        end

        // Jumps redirect but never train or mispredict; non-branches and invalid resolves idle
        s_fetch_pc = 32'h44;
        tick(-1, -1, -1, -1, 0);
        res(32'h44, BEQ, 32'd6, 32'd6, 1'b0, 1'b1, 1'b0); tick(0, -1, 1, 0, 0);
        res(32'h44, BEQ, 32'd6, 32'd7, 1'b0, 1'b1, 1'b0); tick(0, -1, 1, 0, 0);
        res(32'h44, BEQ, 32'd6, 32'd6, 1'b0, 1'b0, 1'b0); tick(0, -1, 0, 0, 0);
        res(32'h44, BEQ, 32'd6, 32'd6, 1'b1, 1'b0, 1'b0); s_rv = 1'b0; tick(0, -1, 0, 0, 0);
        tick(0, 0, -1, -1, 0);
        tick(0, 0, -1, -1, 0);

        // Clear sweep with a same-cycle resolve, resolves and a second clear mid-sweep
        s_fetch_pc = 32'h40;
        s_clear = 1'b1;
        res(32'h48, BEQ, 32'd1, 32'd1, 1'b1, 1'b0, 1'b0);
        tick(1, 0, 1, 1, 0);
        for (int k = 0; k < 64; k++) begin
            if (k == 10) s_clear = 1'b1;
            if (k >= 40 && k < 50) begin
                res(32'h48, BEQ, 32'd1, 32'd1, 1'b1, 1'b0, 1'b0);
                tick(0, 1, 1, 1, k == 0);
            end else begin
                tick(0, 1, -1, -1, k == 0);
            end
        end
        tick(0, 0, -1, -1, 0);
        tick(0, 0, -1, -1, 0);
        for (int i = 0; i < 64; i++) begin
            s_fetch_pc = 32'(i * 4);
            tick(0, 0, -1, -1, 0);
        end
        s_fetch_pc = 32'h48;
        res(32'h48, BEQ, 32'd1, 32'd1, 1'b1, 1'b0, 1'b0);
        tick(0, 0, 1, 1, 0);
        tick(1, 0, -1, -1, 0);

        // Reset in the middle of a sweep
        s_fetch_pc = 32'h4C;
        res(32'h4C, BEQ, 32'd2, 32'd2, 1'b1, 1'b0, 1'b0);
        tick(0, 0, 1, 1, 0);
        tick(1, 0, -1, -1, 0);
        tick(1, 0, -1, -1, 0);
        s_clear = 1'b1;
        tick(1, 0, -1, -1, 0);
        repeat (10) tick(0, 1, -1, -1, 0);
        s_rst_n = 1'b0;
        tick(0, 0, 0, 0, 1);
        s_rst_n = 1'b1;
        tick(0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 1);
        res(32'h4C, BEQ, 32'd2, 32'd2, 1'b1, 1'b0, 1'b0);
        tick(0, 0, 1, 1, 0);
        tick(1, 0, -1, -1, 0);

        tick(-1, -1, -1, -1, 0);
        tick(-1, -1, -1, -1, 0);
        checks++;
        if (exp_q.size() != 0 || seen != issued) begin
            errors++;
            $display("FAIL drain actual=%0d pending required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
